nvio_ipt_arb: RTL and testbench

Two-port arbiter and sequencer that shares the single inverted-page-table MMU (virtual-address bus in, physical bus out) between the instruction-fetch port (m0) and the data load/store port (m1). It grants one requester at a time, fair round-robin, and holds the grant for a whole bus cycle, bursts included. It routes ack, read data and violation flags back to the granted requester only. It also aborts a cycle on page fault or bus timeout, so a stuck cycle cannot lock the MMU.

---
 rtl/nvio_ipt_arb.sv | 228 ++++++++++++++++++++++
 tb/tb_nvio_ipt_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nvio_ipt_arb.sv
// Round-robin arbiter that shares the inverted-page-table MMU between the instruction-fetch (m0)
// and load/store (m1) ports, with page-fault and no-ack timeout abort.
module nvio_ipt_arb #(
    parameter int unsigned TMO_BITS = 8
) (
    input  logic          rst,
    input  logic          clk,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic          m0_cs_i,
    input  logic [15:0]   m0_sel_i,
    input  logic [63:0]   m0_vadr_i,
    input  logic [63:0]   m0_dat_i,
    input  logic [1:0]    m0_bte_i,
    input  logic [2:0]    m0_cti_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [63:0]   m0_dat_o,
    output logic          m0_exv_o,
    output logic          m0_rdv_o,
    output logic          m0_wrv_o,
    output logic          m0_prv_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic          m1_cs_i,
    input  logic [15:0]   m1_sel_i,
    input  logic [63:0]   m1_vadr_i,
    input  logic [63:0]   m1_dat_i,
    input  logic [1:0]    m1_bte_i,
    input  logic [2:0]    m1_cti_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [63:0]   m1_dat_o,
    output logic          m1_exv_o,
    output logic          m1_rdv_o,
    output logic          m1_wrv_o,
    output logic          m1_prv_o,

    output logic          mmu_cyc_o,
    output logic          mmu_stb_o,
    output logic          mmu_we_o,
    output logic          mmu_cs_o,
    output logic          mmu_icl_o,
    output logic [15:0]   mmu_sel_o,
    output logic [63:0]   mmu_vadr_o,
    output logic [63:0]   mmu_dat_o,
    output logic [1:0]    mmu_bte_o,
    output logic [2:0]    mmu_cti_o,
    input  logic          mmu_ack_i,
    input  logic          mmu_page_fault_i,
    input  logic          mmu_exv_i,
    input  logic          mmu_rdv_i,
    input  logic          mmu_wrv_i,
    input  logic          mmu_prv_i,
    input  logic [63:0]   mmu_dat_i
);

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1,
        StAbort
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic [TMO_BITS-1:0] r_tmo;
    logic [TMO_BITS-1:0] w_tmo_nxt;
    logic                r_tmo_err;

    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_granted;
    logic w_cyc_g;
    logic w_tmo_max;
    logic w_tmo_fire;
    logic w_abort_cyc;

    assign w_req0      = m0_cyc_i & m0_stb_i;
    assign w_req1      = m1_cyc_i & m1_stb_i;
    assign w_gnt0      = (r_state == StGnt0);
    assign w_gnt1      = (r_state == StGnt1);
    assign w_granted   = w_gnt0 | w_gnt1;
    assign w_cyc_g     = w_gnt1 ? m1_cyc_i : m0_cyc_i;
    assign w_tmo_max   = &r_tmo;
    // Ack and page fault both take precedence over a timeout in the same cycle.
    assign w_tmo_fire  = w_granted & w_cyc_g & ~mmu_ack_i & ~mmu_page_fault_i & w_tmo_max;
    // r_last still names the aborted port while in StAbort.
    assign w_abort_cyc = r_last ? m1_cyc_i : m0_cyc_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_last    <= 1'b1;
            r_tmo     <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_tmo     <= w_tmo_nxt;
            r_tmo_err <= w_tmo_fire;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        unique case (r_state)
            StIdle: begin
                if (w_req0 && (!w_req1 || r_last)) begin
                    w_state_nxt = StGnt0;
                    w_last_nxt  = 1'b0;
                end else if (w_req1) begin
                    w_state_nxt = StGnt1;
                    w_last_nxt  = 1'b1;
                end
            end
            StGnt0, StGnt1: begin
                if (mmu_page_fault_i) begin
                    w_state_nxt = StAbort;
                end else if (!w_cyc_g) begin
                    w_state_nxt = StIdle;
                end else if (w_tmo_fire) begin
                    w_state_nxt = StAbort;
                end
            end
            StAbort: begin
                if (!w_abort_cyc) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Saturates at all-ones; the abort path leaves it there until IDLE clears it.
    always_comb begin
        w_tmo_nxt = r_tmo;
        if (r_state == StIdle || mmu_ack_i) begin
            w_tmo_nxt = '0;
        end else if (w_granted && w_cyc_g && !w_tmo_max) begin
            w_tmo_nxt = r_tmo + {{(TMO_BITS-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        mmu_cyc_o  = 1'b0;
        mmu_stb_o  = 1'b0;
        mmu_we_o   = 1'b0;
        mmu_cs_o   = 1'b0;
        mmu_icl_o  = 1'b0;
        mmu_sel_o  = '0;
        mmu_vadr_o = '0;
        mmu_dat_o  = '0;
        mmu_bte_o  = '0;
        mmu_cti_o  = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_dat_o   = '0;
        m0_exv_o   = 1'b0;
        m0_rdv_o   = 1'b0;
        m0_wrv_o   = 1'b0;
        m0_prv_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_dat_o   = '0;
        m1_exv_o   = 1'b0;
        m1_rdv_o   = 1'b0;
        m1_wrv_o   = 1'b0;
        m1_prv_o   = 1'b0;

        if (w_gnt0) begin
            mmu_cyc_o  = m0_cyc_i;
            mmu_stb_o  = m0_stb_i;
            mmu_we_o   = m0_we_i;
            mmu_cs_o   = m0_cs_i;
            mmu_icl_o  = 1'b1;
            mmu_sel_o  = m0_sel_i;
            mmu_vadr_o = m0_vadr_i;
            mmu_dat_o  = m0_dat_i;
            mmu_bte_o  = m0_bte_i;
            mmu_cti_o  = m0_cti_i;
            m0_ack_o   = mmu_ack_i & ~mmu_page_fault_i;
            m0_err_o   = mmu_page_fault_i;
            m0_dat_o   = mmu_dat_i;
            m0_exv_o   = mmu_exv_i;
            m0_rdv_o   = mmu_rdv_i;
            m0_wrv_o   = mmu_wrv_i;
            m0_prv_o   = mmu_prv_i;
        end

        if (w_gnt1) begin
            mmu_cyc_o  = m1_cyc_i;
            mmu_stb_o  = m1_stb_i;
            mmu_we_o   = m1_we_i;
            mmu_cs_o   = m1_cs_i;
            mmu_sel_o  = m1_sel_i;
            mmu_vadr_o = m1_vadr_i;
            mmu_dat_o  = m1_dat_i;
            mmu_bte_o  = m1_bte_i;
            mmu_cti_o  = m1_cti_i;
            m1_ack_o   = mmu_ack_i & ~mmu_page_fault_i;
            m1_err_o   = mmu_page_fault_i;
            m1_dat_o   = mmu_dat_i;
            m1_exv_o   = mmu_exv_i;
            m1_rdv_o   = mmu_rdv_i;
            m1_wrv_o   = mmu_wrv_i;
            m1_prv_o   = mmu_prv_i;
        end

        if (r_state == StAbort && r_tmo_err) begin
            if (r_last) begin
                m1_err_o = 1'b1;
            end else begin
                m0_err_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nvio_ipt_arb.sv
// Randomized bench for nvio_ipt_arb: a transaction-level reference model queues the expected
// outputs for each cycle and a negedge monitor pops and compares them.
module tb_nvio_ipt_arb;

    localparam int TB_TMO  = 4;
    localparam int TMO_MAX = (1 << TB_TMO) - 1;
    localparam int N_CYC   = 3000;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic        cs;
        logic [15:0] sel;
        logic [63:0] vadr;
        logic [63:0] dat;
        logic [1:0]  bte;
        logic [2:0]  cti;
    } req_t;

    typedef struct packed {
        logic [153:0] req;
        logic [69:0]  rsp0;
        logic [69:0]  rsp1;
    } obs_t;

    logic clk = 1'b1;
    logic rst;
    req_t rq0;
    req_t rq1;
    logic mack, mpf, mexv, mrdv, mwrv, mprv;
    logic [63:0] mdat;

    logic m0_ack, m0_err, m0_exv, m0_rdv, m0_wrv, m0_prv;
    logic m1_ack, m1_err, m1_exv, m1_rdv, m1_wrv, m1_prv;
    logic [63:0] m0_dat, m1_dat;
    logic mmu_cyc, mmu_stb, mmu_we, mmu_cs, mmu_icl;
    logic [15:0] mmu_sel;
    logic [63:0] mmu_vadr, mmu_dat;
    logic [1:0]  mmu_bte;
    logic [2:0]  mmu_cti;

    always #5 clk = ~clk;

    nvio_ipt_arb #(.TMO_BITS(TB_TMO)) dut (
        .rst(rst), .clk(clk),
        .m0_cyc_i(rq0.cyc), .m0_stb_i(rq0.stb), .m0_we_i(rq0.we), .m0_cs_i(rq0.cs),
        .m0_sel_i(rq0.sel), .m0_vadr_i(rq0.vadr), .m0_dat_i(rq0.dat),
        .m0_bte_i(rq0.bte), .m0_cti_i(rq0.cti),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_dat),
        .m0_exv_o(m0_exv), .m0_rdv_o(m0_rdv), .m0_wrv_o(m0_wrv), .m0_prv_o(m0_prv),
        .m1_cyc_i(rq1.cyc), .m1_stb_i(rq1.stb), .m1_we_i(rq1.we), .m1_cs_i(rq1.cs),
        .m1_sel_i(rq1.sel), .m1_vadr_i(rq1.vadr), .m1_dat_i(rq1.dat),
        .m1_bte_i(rq1.bte), .m1_cti_i(rq1.cti),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_dat),
        .m1_exv_o(m1_exv), .m1_rdv_o(m1_rdv), .m1_wrv_o(m1_wrv), .m1_prv_o(m1_prv),
        .mmu_cyc_o(mmu_cyc), .mmu_stb_o(mmu_stb), .mmu_we_o(mmu_we), .mmu_cs_o(mmu_cs),
        .mmu_icl_o(mmu_icl), .mmu_sel_o(mmu_sel), .mmu_vadr_o(mmu_vadr), .mmu_dat_o(mmu_dat),
        .mmu_bte_o(mmu_bte), .mmu_cti_o(mmu_cti),
        .mmu_ack_i(mack), .mmu_page_fault_i(mpf), .mmu_exv_i(mexv), .mmu_rdv_i(mrdv),
        .mmu_wrv_i(mwrv), .mmu_prv_i(mprv), .mmu_dat_i(mdat)
    );

    // Reference model: who owns the MMU, whether that ownership is being aborted,
    // how long the current cycle has gone unacknowledged, and who won last.
    int m_owner;
    bit m_abort;
    bit m_errp;
    int m_last;
    int m_wait;

    int n_checks = 0;
    int n_pass   = 0;
    bit running  = 1'b0;
    obs_t exp_q[$];
    obs_t mon_exp;

    function automatic req_t port_req(input int p);
        return (p == 1) ? rq1 : rq0;
    endfunction

    function automatic obs_t expect_now();
        obs_t o;
        req_t r;
        logic [69:0] rsp;
        o = '0;
        if (!rst && m_owner >= 0 && !m_abort) begin
            r     = port_req(m_owner);
            o.req = {r.cyc, r.stb, r.we, r.cs, (m_owner == 0), r.sel, r.vadr, r.dat, r.bte, r.cti};
            rsp   = {mack & ~mpf, mpf, mexv, mrdv, mwrv, mprv, mdat};
            if (m_owner == 0) o.rsp0 = rsp;
            else o.rsp1 = rsp;
        end else if (!rst && m_abort && m_errp) begin
            rsp = {1'b0, 1'b1, 68'd0};
            if (m_owner == 0) o.rsp0 = rsp;
            else o.rsp1 = rsp;
        end
        return o;
    endfunction

    task automatic model_step();
        req_t r;
        bit   w0, w1;
        if (rst) begin
            m_owner = -1;
            m_abort = 1'b0;
            m_errp  = 1'b0;
            m_last  = 1;
            m_wait  = 0;
        end else if (m_owner < 0) begin
            m_wait = 0;
            m_errp = 1'b0;
            w0 = rq0.cyc & rq0.stb;
            w1 = rq1.cyc & rq1.stb;
            if (w0 && w1) m_owner = 1 - m_last;
            else if (w0) m_owner = 0;
            else if (w1) m_owner = 1;
            if (m_owner >= 0) m_last = m_owner;
        end else if (m_abort) begin
            m_errp = 1'b0;
            r = port_req(m_owner);
            if (!r.cyc) begin
                m_owner = -1;
                m_abort = 1'b0;
            end
        end else begin
            r = port_req(m_owner);
            if (mpf) begin
                m_abort = 1'b1;
            end else if (!r.cyc) begin
                m_owner = -1;
            end else if (mack) begin
                m_wait = 0;
            end else if (m_wait == TMO_MAX) begin
                m_abort = 1'b1;
                m_errp  = 1'b1;
            end else begin
                m_wait = m_wait + 1;
            end
        end
    endtask

    task automatic gen_port(inout req_t r, input int drop_den);
        if (r.cyc) begin
            if ($urandom_range(drop_den - 1) == 0) r.cyc = 1'b0;
        end else if ($urandom_range(2) == 0) begin
            r.cyc = 1'b1;
        end
        r.stb  = r.cyc & ($urandom_range(3) != 0);
        r.we   = 1'($urandom);
        r.cs   = ($urandom_range(7) == 0);
        r.sel  = 16'($urandom);
        r.vadr = {$urandom, $urandom};
        r.dat  = {$urandom, $urandom};
        r.bte  = 2'($urandom);
        r.cti  = ($urandom_range(1) == 0) ? 3'b010 : 3'($urandom);
    endtask

    function automatic void check(input string name, input logic [153:0] act,
                                  input logic [153:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endfunction

    always @(negedge clk) begin
        if (running) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 154'd1, 154'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("mmu_req",
                      {mmu_cyc, mmu_stb, mmu_we, mmu_cs, mmu_icl, mmu_sel, mmu_vadr, mmu_dat,
                       mmu_bte, mmu_cti}, mon_exp.req);
                check("m0_rsp", 154'({m0_ack, m0_err, m0_exv, m0_rdv, m0_wrv, m0_prv, m0_dat}),
                      154'(mon_exp.rsp0));
                check("m1_rsp", 154'({m1_ack, m1_err, m1_exv, m1_rdv, m1_wrv, m1_prv, m1_dat}),
                      154'(mon_exp.rsp1));
            end
        end
    end

    initial begin
        int phase;
        rst  = 1'b1;
        rq0  = '0;
        rq1  = '0;
        {mack, mpf, mexv, mrdv, mwrv, mprv} = '0;
        mdat = '0;
        m_owner = -1;
        m_abort = 1'b0;
        m_errp  = 1'b0;
        m_last  = 1;
        m_wait  = 0;
        running = 1'b1;

        for (int c = 0; c < N_CYC; c++) begin
            #2;
            // Phase 1 withholds acks so held cycles run into the timeout.
            phase = (c / 500) % 3;
            rst = (c < 3) || ($urandom_range(199) == 0);
            gen_port(rq0, (phase == 1) ? 40 : 8);
            gen_port(rq1, (phase == 1) ? 40 : 8);
            case (phase)
                0: begin
                    mack = ($urandom_range(3) == 0);
                    mpf  = ($urandom_range(59) == 0);
                end
                1: begin
                    mack = 1'b0;
                    mpf  = 1'b0;
                end
                default: begin
                    mack = ($urandom_range(2) == 0);
                    mpf  = ($urandom_range(9) == 0);
                end
            endcase
            {mexv, mrdv, mwrv, mprv} = 4'($urandom);
            mdat = {$urandom, $urandom};
            #1;
            exp_q.push_back(expect_now());
            @(posedge clk);
            model_step();
        end

        #1;
        running = 1'b0;
        check("scoreboard_drained", 154'(exp_q.size()), 154'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
